ultrasonic_tx_scheduler: RTL and testbench
==========================================

Name: ultrasonic_tx_scheduler

Overview:
Time-division scheduler that shares the single ultrasonic transmitter/H-bridge among NUM_CH transducer channels. Per channel it raises the transmitter ON, waits for the burst to start, then times the echo until echo detection or the round-trip flag. It then holds a guard interval so the transducer stops ringing, and moves to the next enabled channel in round-robin order. It sits between the system control registers and the transmitter, and drives the transducer mux select.

Parameters:
NUM_CH, 4, number of transducer channels sharing the transmitter
CH_W, 2, width of channel index (clog2 NUM_CH)
TIME_W, 24, width of echo time-of-flight counter (SYS_CLK cycles)
GUARD_CYCLES, 50000, SYS_CLK cycles with ON low between channels
WATCHDOG_CYCLES, 2000000, max SYS_CLK cycles in ARM waiting for burstStart

Ports:
SYS_CLK  in  1  system clock; only clock
RST  in  1  synchronous, active-high reset
ENABLE  in  1  global scheduler enable
CH_MASK  in  NUM_CH  per-channel enable, sampled at channel selection
burstStart  in  1  one-cycle pulse from transmitter: burst began
roundTripFlag  in  1  one-cycle pulse from transmitter: max range window elapsed
echoValid  in  1  one-cycle pulse from receiver: echo detected
txOn  out  1  ON input of transmitter
chSel  out  CH_W  channel currently owning the transmitter
busy  out  1  high in any state except IDLE
resultValid  out  1  one-cycle pulse: result fields valid
resultCh  out  CH_W  channel of the result
resultHit  out  1  1 = echo seen, 0 = timeout
resultTime  out  TIME_W  cycles from burstStart to echoValid (saturating); 0 on timeout
faultFlag  out  1  one-cycle pulse: watchdog expired in ARM

Behaviour:
- Reset values: state IDLE; txOn 0; chSel 0; busy 0; resultValid 0; resultCh 0; resultHit 0; resultTime 0; faultFlag 0; lastCh NUM_CH-1, so the first grant is channel 0.
- All outputs are registered.
- States: IDLE, ARM, BURST, GUARD.
- IDLE:
  - If ENABLE and CH_MASK is nonzero, pick the first set bit searching from lastCh+1 upward, wrapping modulo NUM_CH.
  - Load chSel and lastCh, clear the watchdog counter, go to ARM.
  - Otherwise stay in IDLE.
- ARM:
  - txOn=1 from the cycle after entry.
  - burstStart: clear the time counter, go to BURST.
  - Watchdog counter reaches WATCHDOG_CYCLES-1 with no burstStart: pulse faultFlag, go to GUARD, no result.
- BURST:
  - txOn=1; the time counter increments every cycle and saturates at all-ones.
  - echoValid: resultValid=1, resultHit=1, resultTime=counter value in that cycle, resultCh=chSel; go to GUARD.
  - roundTripFlag without echoValid: resultValid=1, resultHit=0, resultTime=0; go to GUARD.
  - echoValid and roundTripFlag in the same cycle: echo wins.
  - burstStart in BURST is ignored.
- GUARD:
  - txOn=0; count GUARD_CYCLES cycles, then go to IDLE. The next channel is chosen in IDLE, so there is a 1-cycle IDLE gap.
- ENABLE low in ARM or BURST: go to GUARD next cycle with no result. txOn drops on the following edge. The guard interval always completes.
- ENABLE low in GUARD or IDLE: scheduler settles in IDLE.
- CH_MASK changes mid-operation: the current channel completes. The new mask applies at the next selection.
- Single enabled channel: it is reselected every round.
- echoValid or roundTripFlag outside BURST: ignored.
- RST in any state: all registers return to reset values on the next SYS_CLK edge. txOn is 0 in the cycle after RST is sampled.
- Input contract: burstStart, roundTripFlag and echoValid are SYS_CLK-synchronous single-cycle pulses. The transmitter already produces its pulses in the SYS_CLK domain; no resynchronisation is done here.

Decomposition:
- Shared package:
  - state encoding enum (IDLE=2'd0, ARM=2'd1, BURST=2'd2, GUARD=2'd3);
  - default GUARD_CYCLES and WATCHDOG_CYCLES constants;
  - result record typedef (ch, hit, time).
- One sub-module, rr_channel_picker (combinational round-robin search over CH_MASK from lastCh+1).
  - Inputs: mask and lastCh.
  - Outputs: next index and a found flag.
- FSM and counters stay in the top module.

Test Plan:
- Reset, ENABLE=1, CH_MASK=4'b1111, burstStart 3 cycles after txOn, echoValid 100 cycles later -> resultCh=0, resultHit=1, resultTime=100. The next grants are chSel 1, 2, 3, 0, each preceded by GUARD_CYCLES of txOn=0.
- CH_MASK=4'b1010, roundTripFlag with no echo -> grants alternate 1, 3, 1. Each result has resultHit=0 and resultTime=0.
- echoValid and roundTripFlag asserted in the same cycle, 50 cycles after burstStart -> exactly one resultValid, with resultHit=1 and resultTime=50.
- WATCHDOG_CYCLES=1000, no burstStart -> faultFlag pulses once, 1000 cycles after ARM entry. txOn is low for GUARD_CYCLES, then the next channel is granted. No resultValid.
- ENABLE dropped mid-BURST -> txOn low within 2 cycles, no resultValid, busy low after GUARD_CYCLES+1. Re-enabling grants lastCh+1.
- RST asserted in BURST with time counter at 500 -> next cycle txOn=0, state IDLE, all outputs 0. The first grant after reset is channel 0.

Source files
------------

// File: rtl/ultrasonic_tx_scheduler_pkg.sv
// rtl/ultrasonic_tx_scheduler_pkg.sv - shared types and defaults for the transmitter scheduler
package ultrasonic_tx_scheduler_pkg;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_CH_W            = 2;
  localparam int DEF_TIME_W          = 24;
  localparam int DEF_GUARD_CYCLES    = 50000;
  localparam int DEF_WATCHDOG_CYCLES = 2000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_CH_W-1:0]   ch;
    logic                  hit;
    logic [DEF_TIME_W-1:0] tof;
  } result_t;

endpackage

// File: rtl/ultrasonic_tx_scheduler_rr_channel_picker.sv
// rtl/ultrasonic_tx_scheduler_rr_channel_picker.sv - round-robin search over the channel mask
module rr_channel_picker #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   last_ch,
  output logic [CH_W-1:0]   next_idx,
  output logic              found
);

  // Offsets 1..NUM_CH so the previous owner is considered last.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    next_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (32'(last_ch) + 32'(k)) % 32'(NUM_CH);
      if (!found && mask[cand[CH_W-1:0]]) begin
        found    = 1'b1;
        next_idx = cand[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ultrasonic_tx_scheduler.sv
// rtl/ultrasonic_tx_scheduler.sv - time-division sharing of one transmitter among transducer channels
module ultrasonic_tx_scheduler
  import ultrasonic_tx_scheduler_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int CH_W            = DEF_CH_W,
  parameter int TIME_W          = DEF_TIME_W,
  parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic [NUM_CH-1:0] CH_MASK,
  input  logic              burstStart,
  input  logic              roundTripFlag,
  input  logic              echoValid,
  output logic              txOn,
  output logic [CH_W-1:0]   chSel,
  output logic              busy,
  output logic              resultValid,
  output logic [CH_W-1:0]   resultCh,
  output logic              resultHit,
  output logic [TIME_W-1:0] resultTime,
  output logic              faultFlag
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam int GD_W = $clog2(GUARD_CYCLES + 1);

  state_t            state, state_n;
  logic [CH_W-1:0]   last_ch, pick_idx;
  logic              pick_found;
  logic [WD_W-1:0]   wd_cnt;
  logic [GD_W-1:0]   guard_cnt;
  logic [TIME_W-1:0] tof_cnt, tof_next;
  logic              wd_done, guard_done, fault_n, result_n;

  rr_channel_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .mask     (CH_MASK),
    .last_ch  (last_ch),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  assign wd_done    = (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
  assign guard_done = (guard_cnt == GD_W'(GUARD_CYCLES - 1));
  // The echo cycle itself counts, so an echo N cycles after burstStart reports N.
  assign tof_next   = (&tof_cnt) ? tof_cnt : tof_cnt + TIME_W'(1);

  always_comb begin
    state_n  = state;
    fault_n  = 1'b0;
    result_n = 1'b0;
    case (state)
      ST_IDLE: if (ENABLE && pick_found) state_n = ST_ARM;
      ST_ARM: begin
        if (!ENABLE) begin
          state_n = ST_GUARD;
        end else if (burstStart) begin
          state_n = ST_BURST;
        end else if (wd_done) begin
          state_n = ST_GUARD;
          fault_n = 1'b1;
        end
      end
      ST_BURST: begin
        if (!ENABLE) begin
          state_n = ST_GUARD;
        end else if (echoValid || roundTripFlag) begin
          state_n  = ST_GUARD;
          result_n = 1'b1;
        end
      end
      ST_GUARD: if (guard_done) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      last_ch     <= CH_W'(NUM_CH - 1);
      wd_cnt      <= '0;
      guard_cnt   <= '0;
      tof_cnt     <= '0;
      txOn        <= 1'b0;
      chSel       <= '0;
      busy        <= 1'b0;
      resultValid <= 1'b0;
      resultCh    <= '0;
      resultHit   <= 1'b0;
      resultTime  <= '0;
      faultFlag   <= 1'b0;
    end else begin
      state       <= state_n;
      txOn        <= (state == ST_ARM) || (state == ST_BURST);
      busy        <= (state_n != ST_IDLE);
      resultValid <= result_n;
      faultFlag   <= fault_n;
      if (result_n) begin
        resultCh   <= chSel;
        resultHit  <= echoValid;
        resultTime <= echoValid ? tof_next : '0;
      end
      case (state)
        ST_IDLE: begin
          if (state_n == ST_ARM) begin
            chSel   <= pick_idx;
            last_ch <= pick_idx;
            wd_cnt  <= '0;
          end
        end
        ST_ARM: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (burstStart) tof_cnt <= '0;
        end
        ST_BURST: tof_cnt   <= tof_next;
        ST_GUARD: guard_cnt <= guard_cnt + GD_W'(1);
        default: ;
      endcase
      if (state_n == ST_GUARD && state != ST_GUARD) guard_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ultrasonic_tx_scheduler.sv
// tb/tb_ultrasonic_tx_scheduler.sv - scoreboard bench for the transmitter scheduler
module tb_ultrasonic_tx_scheduler;
  import ultrasonic_tx_scheduler_pkg::*;

  localparam int G  = 20;
  localparam int WD = 1000;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic [3:0]  CH_MASK = 4'b0000;
  logic        burstStart = 1'b0;
  logic        roundTripFlag = 1'b0;
  logic        echoValid = 1'b0;
  logic        txOn, busy, resultValid, resultHit, faultFlag;
  logic [1:0]  chSel, resultCh;
  logic [23:0] resultTime;

  always #5 SYS_CLK = ~SYS_CLK;

  ultrasonic_tx_scheduler #(
    .NUM_CH(4), .CH_W(2), .TIME_W(24), .GUARD_CYCLES(G), .WATCHDOG_CYCLES(WD)
  ) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .ENABLE(ENABLE), .CH_MASK(CH_MASK),
    .burstStart(burstStart), .roundTripFlag(roundTripFlag), .echoValid(echoValid),
    .txOn(txOn), .chSel(chSel), .busy(busy), .resultValid(resultValid),
    .resultCh(resultCh), .resultHit(resultHit), .resultTime(resultTime),
    .faultFlag(faultFlag)
  );

  int      pass_cnt = 0;
  int      total_cnt = 0;
  int      grant_q[$];
  int      fault_q[$];
  result_t res_q[$];
  result_t exp_res;
  int      low_run = 0;
  int      cyc = 0;
  bit      busy_q = 1'b0;
  bit      skip_guard = 1'b1;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: grants, results and faults are popped against the expected queues.
  always @(negedge SYS_CLK) begin
    cyc++;
    low_run = txOn ? 0 : low_run + 1;
    if (busy && !busy_q) begin
      if (grant_q.size() == 0) check("unexpected_grant_ch", int'(chSel), -1);
      else check("grant_ch", int'(chSel), grant_q.pop_front());
      if (!skip_guard) check("guard_txon_low_cycles", low_run, G + 1);
      skip_guard = 1'b0;
      cyc = 0;
    end
    busy_q = busy;
    if (resultValid) begin
      if (res_q.size() == 0) begin
        check("unexpected_result_ch", int'(resultCh), -1);
      end else begin
        exp_res = res_q.pop_front();
        check("result_ch", int'(resultCh), int'(exp_res.ch));
        check("result_hit", int'(resultHit), int'(exp_res.hit));
        check("result_time", int'(resultTime), int'(exp_res.tof));
      end
    end
    if (faultFlag) begin
      if (fault_q.size() == 0) check("unexpected_fault_cycles", cyc, -1);
      else check("fault_cycles_after_arm", cyc, fault_q.pop_front());
    end
  end

  task automatic wait_txon();
    int n = 0;
    while (txOn && n < 200) begin @(negedge SYS_CLK); n++; end
    n = 0;
    while (!txOn && n < 3000) begin @(negedge SYS_CLK); n++; end
    if (!txOn) check("txon_rise_timeout", int'(txOn), 1);
  endtask

  task automatic do_channel(int ch, int d, bit echo, bit rt);
    result_t r;
    grant_q.push_back(ch);
    wait_txon();
    repeat (3) @(negedge SYS_CLK);
    burstStart = 1'b1;
    @(negedge SYS_CLK);
    burstStart = 1'b0;
    repeat (d - 1) @(negedge SYS_CLK);
    echoValid = echo;
    roundTripFlag = rt;
    if (echo || rt) begin
      r.ch  = 2'(ch);
      r.hit = echo;
      r.tof = echo ? 24'(d) : 24'd0;
      res_q.push_back(r);
    end
    @(negedge SYS_CLK);
    echoValid = 1'b0;
    roundTripFlag = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_txOn"}, int'(txOn), 0);
    check({tag, "_chSel"}, int'(chSel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_resultValid"}, int'(resultValid), 0);
    check({tag, "_resultCh"}, int'(resultCh), 0);
    check({tag, "_resultHit"}, int'(resultHit), 0);
    check({tag, "_resultTime"}, int'(resultTime), 0);
    check({tag, "_faultFlag"}, int'(faultFlag), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge SYS_CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    ENABLE = 1'b1;
    CH_MASK = 4'b1111;

    do_channel(0, 100, 1'b1, 1'b0);
    do_channel(1, 7, 1'b1, 1'b0);
    do_channel(2, 20, 1'b1, 1'b0);
    do_channel(3, 33, 1'b1, 1'b0);
    do_channel(0, 64, 1'b1, 1'b0);
    CH_MASK = 4'b1010;

    do_channel(1, 40, 1'b0, 1'b1);
    do_channel(3, 12, 1'b0, 1'b1);
    do_channel(1, 25, 1'b0, 1'b1);

    do_channel(3, 50, 1'b1, 1'b1);

    // Watchdog: grant without any burstStart.
    grant_q.push_back(1);
    fault_q.push_back(WD);
    wait_txon();
    n = 0;
    while (!faultFlag && n < WD + 50) begin @(negedge SYS_CLK); n++; end
    check("fault_seen", int'(faultFlag), 1);

    // ENABLE dropped mid-burst.
    grant_q.push_back(3);
    wait_txon();
    repeat (3) @(negedge SYS_CLK);
    burstStart = 1'b1;
    @(negedge SYS_CLK);
    burstStart = 1'b0;
    repeat (30) @(negedge SYS_CLK);
    ENABLE = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    check("disable_txon_low", int'(txOn), 0);
    repeat (G - 2) @(negedge SYS_CLK);
    check("disable_busy_in_guard", int'(busy), 1);
    @(negedge SYS_CLK);
    check("disable_busy_after_guard", int'(busy), 0);
    repeat (5) @(negedge SYS_CLK);
    check("disable_idle_hold", int'(busy), 0);
    skip_guard = 1'b1;
    grant_q.push_back(1);
    ENABLE = 1'b1;

    // Reset while timing an echo.
    wait_txon();
    repeat (3) @(negedge SYS_CLK);
    burstStart = 1'b1;
    @(negedge SYS_CLK);
    burstStart = 1'b0;
    repeat (500) @(negedge SYS_CLK);
    RST = 1'b1;
    @(negedge SYS_CLK);
    check_reset_outputs("midburst_reset");
    CH_MASK = 4'b1111;
    skip_guard = 1'b1;
    RST = 1'b0;
    do_channel(0, 9, 1'b1, 1'b0);
    ENABLE = 1'b0;
    repeat (G + 5) @(negedge SYS_CLK);
    check("final_busy", int'(busy), 0);
    check("grants_left", grant_q.size(), 0);
    check("results_left", res_q.size(), 0);
    check("faults_left", fault_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
